jacob_to_affine: RTL and testbench

Parametrised converter from Jacobian projective (X, Y, Z) to affine (x, y) = (X·Z⁻², Y·Z⁻³) mod p, with both coordinates produced in one pass.
- Computes Z⁻¹ with a one-step-per-cycle binary extended Euclidean inverter, then runs four sequential modular multiplies.
- Sits after the point add/double datapath and feeds scalar-multiplication results to the host side.
- Replaces the single-coordinate search-based x converter, which has unbounded latency; this block's latency is bounded.

---
 rtl/ecc_pkg.sv | 23 ++
 rtl/mod_mul_serial.sv | 67 ++++++
 rtl/jacob_to_affine.sv | 198 +++++++++++++++++++
 tb/tb_jacob_to_affine.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC point datapath: converter FSM states and
// latency helpers.
package ecc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INV,
    MUL_Z2,
    MUL_Z3,
    MUL_X,
    MUL_Y,
    DONE
  } state_t;

  // Modular multiplies needed per Jacobian-to-affine conversion.
  localparam int unsigned NUM_MULS = 4;

  // Worst-case cycles from the start cycle through the done cycle, inclusive.
  function automatic int unsigned max_latency(input int unsigned width);
    return 2 * width + NUM_MULS * (width + 1) + 2;
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier, MSB first.
// A go cycle loads the operands, then WIDTH bit steps follow. rdy is high
// during the final step, and r then carries the finished product a*b mod p.
module mod_mul_serial #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             rdy,
  output logic [WIDTH-1:0] r
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    cnt_q;
  logic             active_q;

  logic [WIDTH:0]   dbl;
  logic [WIDTH:0]   dbl_red;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] acc_red;

  // One step: r = 2r mod p, then add a when the current multiplier bit is set.
  always_comb begin
    dbl     = {r_q, 1'b0};
    dbl_red = (dbl >= {1'b0, p_q}) ? dbl - {1'b0, p_q} : dbl;
    acc     = dbl_red + (b_q[WIDTH-1] ? {1'b0, a_q} : '0);
    acc_red = (acc >= {1'b0, p_q}) ? WIDTH'(acc - {1'b0, p_q}) : WIDTH'(acc);
    rdy     = active_q && (cnt_q == CW'(1));
    r       = acc_red;
  end

  // Operand load on go, then one multiplier bit per cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (go) begin
      a_q      <= a;
      b_q      <= b;
      p_q      <= p;
      r_q      <= '0;
      cnt_q    <= CW'(WIDTH);
      active_q <= 1'b1;
    end else if (active_q) begin
      r_q   <= acc_red;
      b_q   <= b_q << 1;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jacob_to_affine.sv
// Jacobian (X, Y, Z) to affine (X/Z^2, Y/Z^3) mod p converter.
// An inline binary extended-Euclid inverter finds Z^-1, then a shared serial
// multiplier forms Z^-2, Z^-3, x and y in turn. Z = 0 maps to infinity.
module jacob_to_affine #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] y3,
  input  logic [WIDTH-1:0] z3,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             inf
);

  import ecc_pkg::*;

  state_t state_q;
  state_t state_n;

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] u_q;
  logic [WIDTH-1:0] v_q;
  logic [WIDTH-1:0] ia_q;
  logic [WIDTH-1:0] ib_q;
  logic [WIDTH-1:0] zinv_q;
  logic [WIDTH-1:0] z2_q;
  logic [WIDTH-1:0] z3i_q;
  logic [WIDTH-1:0] xr_q;

  logic             u_one;
  logic             v_one;
  logic             inv_exit;

  logic             mul_go_q;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_rdy;
  logic [WIDTH-1:0] mul_r;

  // (val / 2) mod p for odd p: add p first when val is odd.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] val,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, val} + (val[0] ? {1'b0, m} : '0);
    return WIDTH'(s >> 1);
  endfunction

  // (lhs - rhs) mod p with both operands already reduced.
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] lhs,
                                               input logic [WIDTH-1:0] rhs,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] d;
    d = {1'b0, lhs} - {1'b0, rhs};
    if (d[WIDTH]) begin
      d = d + {1'b0, m};
    end
    return WIDTH'(d);
  endfunction

  // A zero u or v only arises for a non-invertible Z. Leaving on it keeps
  // the latency bounded instead of halving zero forever.
  always_comb begin
    u_one    = (u_q == WIDTH'(1));
    v_one    = (v_q == WIDTH'(1));
    inv_exit = u_one || v_one || (u_q == '0) || (v_q == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (start) state_n = (z3 == '0) ? DONE : INV;
      INV:     if (inv_exit) state_n = MUL_Z2;
      MUL_Z2:  if (mul_rdy) state_n = MUL_Z3;
      MUL_Z3:  if (mul_rdy) state_n = MUL_X;
      MUL_X:   if (mul_rdy) state_n = MUL_Y;
      MUL_Y:   if (mul_rdy) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status outputs and multiplier operand selection.
  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      MUL_Z2: begin mul_a = zinv_q; mul_b = zinv_q; end
      MUL_Z3: begin mul_a = z2_q;   mul_b = zinv_q; end
      MUL_X:  begin mul_a = x_q;    mul_b = z2_q;   end
      MUL_Y:  begin mul_a = y_q;    mul_b = z3i_q;  end
      default: ;
    endcase
  end

  // Datapath: operand latch, inverter steps, product capture, result update.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_q      <= '0;
      y_q      <= '0;
      p_q      <= '0;
      u_q      <= '0;
      v_q      <= '0;
      ia_q     <= '0;
      ib_q     <= '0;
      zinv_q   <= '0;
      z2_q     <= '0;
      z3i_q    <= '0;
      xr_q     <= '0;
      mul_go_q <= 1'b0;
      x        <= '0;
      y        <= '0;
      inf      <= 1'b0;
    end else begin
      mul_go_q <= (state_n != state_q) &&
                  (state_n inside {MUL_Z2, MUL_Z3, MUL_X, MUL_Y});
      unique case (state_q)
        IDLE: begin
          if (start) begin
            x_q  <= x3;
            y_q  <= y3;
            p_q  <= p;
            u_q  <= z3;
            v_q  <= p;
            ia_q <= WIDTH'(1);
            ib_q <= '0;
            if (z3 == '0) begin
              x   <= '0;
              y   <= '0;
              inf <= 1'b1;
            end
          end
        end
        INV: begin
          if (inv_exit) begin
            zinv_q <= u_one ? ia_q : (v_one ? ib_q : ia_q);
          end else if (!u_q[0]) begin
            u_q  <= u_q >> 1;
            ia_q <= half_mod(ia_q, p_q);
          end else if (!v_q[0]) begin
            v_q  <= v_q >> 1;
            ib_q <= half_mod(ib_q, p_q);
          end else if (u_q >= v_q) begin
            u_q  <= u_q - v_q;
            ia_q <= sub_mod(ia_q, ib_q, p_q);
          end else begin
            v_q  <= v_q - u_q;
            ib_q <= sub_mod(ib_q, ia_q, p_q);
          end
        end
        MUL_Z2: if (mul_rdy) z2_q  <= mul_r;
        MUL_Z3: if (mul_rdy) z3i_q <= mul_r;
        MUL_X:  if (mul_rdy) xr_q  <= mul_r;
        MUL_Y: begin
          if (mul_rdy) begin
            x   <= xr_q;
            y   <= mul_r;
            inf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  mod_mul_serial #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk  (clk),
    .nrst (nrst),
    .go   (mul_go_q),
    .a    (mul_a),
    .b    (mul_b),
    .p    (p_q),
    .rdy  (mul_rdy),
    .r    (mul_r)
  );

endmodule

// File: tb/tb_jacob_to_affine.sv
// Scoreboard bench for jacob_to_affine at WIDTH=8 with hand-computed vectors.
module tb_jacob_to_affine;

  localparam int unsigned W = 8;
  localparam int MAX_LAT = 2 * W + 4 * (W + 1) + 2;

  logic         clk = 1'b0;
  logic         nrst;
  logic         start;
  logic [W-1:0] x3, y3, z3, p;
  logic         busy, done, inf;
  logic [W-1:0] x, y;

  jacob_to_affine #(.WIDTH(W)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .start (start),
    .x3    (x3),
    .y3    (y3),
    .z3    (z3),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .x     (x),
    .y     (y),
    .inf   (inf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int dones    = 0;
  int accepts  = 0;

  typedef struct {
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    logic         einf;
    bit           chk_xy;
    int           exact_lat;
    int           issue;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (nrst && done) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        mon_e = sb.pop_front();
        check("inf", inf, mon_e.einf);
        if (mon_e.chk_xy) begin
          check("x", x, mon_e.ex);
          check("y", y, mon_e.ey);
        end
        mon_lat = cyc - mon_e.issue + 1;
        if (mon_e.exact_lat > 0) check("latency_exact", mon_lat, mon_e.exact_lat);
        else                     check("latency_bound", mon_lat <= MAX_LAT, 1);
      end
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_exp(input logic [W-1:0] ex, input logic [W-1:0] ey, input logic einf,
                          input bit chk, input int exact);
    exp_t e;
    e.ex = ex; e.ey = ey; e.einf = einf; e.chk_xy = chk; e.exact_lat = exact; e.issue = cyc;
    sb.push_back(e);
    accepts++;
  endtask

  task automatic run_vec(input logic [W-1:0] vp, input logic [W-1:0] vx, input logic [W-1:0] vy,
                         input logic [W-1:0] vz, input logic [W-1:0] ex, input logic [W-1:0] ey,
                         input logic einf, input bit chk, input int exact);
    bit ok;
    wait_idle(ok);
    check("idle_before_start", ok, 1);
    p = vp; x3 = vx; y3 = vy; z3 = vz; start = 1'b1;
    push_exp(ex, ey, einf, chk, exact);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    bit ok;
    nrst = 1'b0; start = 1'b0; x3 = '0; y3 = '0; z3 = '0; p = 8'd23;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_inf", inf, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    nrst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("no_done_on_reset_exit", done, 0);
    end

    //      p    X    Y    Z    x    y  inf chk exact
    run_vec(23,   5,  10,   2,   7,   7, 0, 1, 0);
    run_vec(23,  22,   3,   1,  22,   3, 0, 1, 39);
    run_vec(23,  17,   9,   0,   0,   0, 1, 1, 2);
    run_vec(23,   3,   4,   5,  13,   5, 0, 1, 0);
    run_vec(251, 100, 200, 250, 100, 51, 0, 1, 0);
    run_vec(3,    2,   1,   2,   2,   2, 0, 1, 0);
    run_vec(13,  12,  12,  12,  12,   1, 0, 1, 0);
    run_vec(251,  0,   0,   7,   0,   0, 0, 1, 0);
    run_vec(15,   4,   5,   3,   0,   0, 0, 0, 0);

    // start held high through a run while the inputs change underneath it;
    // the IDLE cycle after done accepts whatever is then presented.
    wait_idle(ok);
    check("idle_before_hold", ok, 1);
    p = 23; x3 = 3; y3 = 4; z3 = 5; start = 1'b1;
    push_exp(13, 5, 0, 1, 0);
    @(posedge clk);
    #1 x3 = 1; y3 = 2; z3 = 0;
    @(negedge clk);
    check("hold_busy", busy, 1);
    repeat (10) @(negedge clk);
    x3 = 12; y3 = 9; z3 = 5;
    wait_idle(ok);
    check("hold_idle_reached", ok, 1);
    push_exp(6, 17, 0, 1, 0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("back_to_back_busy", busy, 1);

    // Reset while MUL_X is in progress.
    wait_idle(ok);
    check("idle_before_reset_run", ok, 1);
    p = 23; x3 = 5; y3 = 10; z3 = 2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (24) @(negedge clk);
    check("busy_before_reset", busy, 1);
    nrst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_inf", inf, 0);
    check("midrst_x", x, 0);
    check("midrst_y", y, 0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_midrst", done, 0);
    end
    run_vec(23, 5, 10, 2, 7, 7, 0, 1, 0);

    wait_idle(ok);
    check("final_idle", ok, 1);
    check("scoreboard_empty", sb.size(), 0);
    check("done_count", dones, accepts);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
